// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the data-memory arbiter: grant/state encodings and
// default geometry. The SPI sequencer and its testbench import this package
// so that they agree with the arbiter on encodings and widths.
//   ST_IDLE / ST_ACC_A / ST_ACC_B : arbiter state (= registered grant)
//   DEF_ADDR_W / DEF_DATA_W       : default memory geometry (128 x 8)
//   DEF_B_MAX_WAIT                : default port B starvation bound
package mem_arbiter_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_ACC_A = 2'd1;
    localparam logic [STATE_W-1:0] ST_ACC_B = 2'd2;

    localparam int DEF_ADDR_W     = 7;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_B_MAX_WAIT = 15;

    // Counter width able to hold 0..max_val (never narrower than one bit).
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// arb_wait_counter
// Saturating counter tracking how long port B has been kept waiting.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset (count -> 0)
//   clr    in  clear the count (B granted or request withdrawn); wins over inc
//   inc    in  B waited this cycle
//   count  out current count, saturates at MAX
//   boost  out count has reached MAX: B now outranks a newly arriving A request
module arb_wait_counter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX = DEF_B_MAX_WAIT,
    parameter int CW  = cnt_width(DEF_B_MAX_WAIT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          boost
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg < MAX_C)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign boost = (count_reg >= MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port data memory between the SPI slave sequencer (port A,
// pulse requests, hard real-time) and a local host (port B, level request with
// acknowledge). Every access takes exactly one cycle; A normally wins, but a B
// request that has waited B_MAX_WAIT cycles is boosted above a new A request.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata        A command (one-cycle pulse)
//   a_valid/a_rdata                  A completion pulse and read data
//   a_overrun                        sticky: a_req while an A request pending
//   b_req/b_we/b_addr/b_wdata        B command (level, held until b_ack)
//   b_ack/b_rdata                    B completion pulse and read data
//   mem_we/mem_addr/mem_wdata        memory command (arbiter is sole driver)
//   mem_rdata                        memory combinational read data
//   busy                             high during any access cycle
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int B_MAX_WAIT = DEF_B_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_valid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_overrun,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CW = cnt_width(B_MAX_WAIT);

    // Arbiter state; it is also the registered grant for the current cycle.
    logic [STATE_W-1:0] state_reg;
    logic [STATE_W-1:0] state_next;

    // Queued A command waiting for a grant.
    logic              pend_reg;
    logic              pend_we_reg;
    logic [ADDR_W-1:0] pend_addr_reg;
    logic [DATA_W-1:0] pend_wdata_reg;
    logic              overrun_reg;

    // Memory command registers, loaded at the grant edge.
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    // Completion outputs.
    logic              a_valid_reg;
    logic [DATA_W-1:0] a_rdata_reg;
    logic              b_ack_reg;
    logic [DATA_W-1:0] b_rdata_reg;

    // Arbitration terms.
    logic              a_avail;
    logic              a_cmd_we;
    logic [ADDR_W-1:0] a_cmd_addr;
    logic [DATA_W-1:0] a_cmd_wdata;
    logic              b_elig;
    logic              grant_a;
    logic              grant_b;
    logic              boost;
    logic [CW-1:0]     wait_cnt;

    // A queued command always takes precedence over a fresh pulse; a pulse
    // arriving while one is queued is the overrun case and is dropped.
    always_comb begin
        a_avail     = pend_reg | a_req;
        a_cmd_we    = pend_reg ? pend_we_reg    : a_we;
        a_cmd_addr  = pend_reg ? pend_addr_reg  : a_addr;
        a_cmd_wdata = pend_reg ? pend_wdata_reg : a_wdata;
    end

    // While B is being accessed its ack is not yet visible (it rises at the
    // closing edge), so the in-flight access must also block re-service of
    // the still-held b_req.
    always_comb begin
        b_elig  = b_req & ~b_ack_reg & (state_reg != ST_ACC_B);
        grant_a = a_avail & ~(b_elig & boost);
        grant_b = b_elig & ~grant_a;
    end

    always_comb begin
        state_next = ST_IDLE;
        if (grant_a) begin
            state_next = ST_ACC_A;
        end else if (grant_b) begin
            state_next = ST_ACC_B;
        end
    end

    arb_wait_counter #(
        .MAX (B_MAX_WAIT),
        .CW  (CW)
    ) u_wait_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (grant_b | ~b_req),
        .inc   (b_elig & ~grant_b),
        .count (wait_cnt),
        .boost (boost)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Pending A register and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg       <= 1'b0;
            pend_we_reg    <= 1'b0;
            pend_addr_reg  <= '0;
            pend_wdata_reg <= '0;
            overrun_reg    <= 1'b0;
        end else begin
            if (grant_a) begin
                pend_reg <= 1'b0;
            end else if (a_req && !pend_reg) begin
                pend_reg       <= 1'b1;
                pend_we_reg    <= a_we;
                pend_addr_reg  <= a_addr;
                pend_wdata_reg <= a_wdata;
            end
            if (a_req && pend_reg) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // Memory command: address/data hold their last values when idle, only
    // the write enable returns low. The async clear of mem_we_reg is what
    // aborts a write when reset hits mid-access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            if (grant_a) begin
                mem_we_reg    <= a_cmd_we;
                mem_addr_reg  <= a_cmd_addr;
                mem_wdata_reg <= a_cmd_wdata;
            end else if (grant_b) begin
                mem_we_reg    <= b_we;
                mem_addr_reg  <= b_addr;
                mem_wdata_reg <= b_wdata;
            end else begin
                mem_we_reg    <= 1'b0;
            end
        end
    end

    // Read data is captured at the closing edge of every access, writes
    // included, so a write returns the previous contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_reg <= 1'b0;
            a_rdata_reg <= '0;
            b_ack_reg   <= 1'b0;
            b_rdata_reg <= '0;
        end else begin
            a_valid_reg <= (state_reg == ST_ACC_A);
            b_ack_reg   <= (state_reg == ST_ACC_B);
            if (state_reg == ST_ACC_A) begin
                a_rdata_reg <= mem_rdata;
            end
            if (state_reg == ST_ACC_B) begin
                b_rdata_reg <= mem_rdata;
            end
        end
    end

    assign a_valid   = a_valid_reg;
    assign a_rdata   = a_rdata_reg;
    assign a_overrun = overrun_reg;
    assign b_ack     = b_ack_reg;
    assign b_rdata   = b_rdata_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with a behavioural 128x8 memory.
module tb_mem_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_req;
    logic       a_we;
    logic [6:0] a_addr;
    logic [7:0] a_wdata;
    logic       a_valid;
    logic [7:0] a_rdata;
    logic       a_overrun;
    logic       b_req;
    logic       b_we;
    logic [6:0] b_addr;
    logic [7:0] b_wdata;
    logic       b_ack;
    logic [7:0] b_rdata;
    logic       mem_we;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;

    logic [7:0] mem [128] = '{default: 8'h00};

    int n_tests = 0;
    int n_fail  = 0;
    int b_ack_cycle;
    int av_count;

    mem_arbiter #(
        .ADDR_W     (7),
        .DATA_W     (8),
        .B_MAX_WAIT (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_valid   (a_valid),
        .a_rdata   (a_rdata),
        .a_overrun (a_overrun),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

        // ---- reset state
        tick();
        tick();
        chk("rst_a_valid",   a_valid,   0);
        chk("rst_a_rdata",   a_rdata,   0);
        chk("rst_a_overrun", a_overrun, 0);
        chk("rst_b_ack",     b_ack,     0);
        chk("rst_b_rdata",   b_rdata,   0);
        chk("rst_mem_we",    mem_we,    0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy",      busy,      0);
        $display("[TB] reset checked");
        rst_n = 1'b1;
        tick();

        // ---- B writes 0xA5 to 0x10, then A reads it back
        b_req = 1'b1; b_we = 1'b1; b_addr = 7'h10; b_wdata = 8'hA5;
        tick();
        chk("bw_mem_we",   mem_we,   1);
        chk("bw_mem_addr", mem_addr, 7'h10);
        chk("bw_busy",     busy,     1);
        tick();
        chk("bw_b_ack",    b_ack,    1);
        chk("bw_b_rdata",  b_rdata,  8'h00);
        chk("bw_mem_we_off", mem_we, 0);
        b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 7'h10;
        tick();
        a_req = 1'b0;
        chk("ar_b_ack_pulse", b_ack,    0);
        chk("ar_mem_addr",    mem_addr, 7'h10);
        tick();
        chk("ar_a_valid", a_valid, 1);
        chk("ar_a_rdata", a_rdata, 8'hA5);
        $display("[TB] B write 0x10=A5, A read back %0h", a_rdata);

        // ---- A write and B read of the same address in the same cycle
        a_req = 1'b1; a_we = 1'b1; a_addr = 7'h20; a_wdata = 8'h3C;
        b_req = 1'b1; b_we = 1'b0; b_addr = 7'h20;
        tick();
        a_req = 1'b0;
        chk("ab_first_we",   mem_we,   1);
        chk("ab_first_addr", mem_addr, 7'h20);
        tick();
        chk("ab_a_valid",    a_valid,  1);
        chk("ab_b_ack_early", b_ack,   0);
        chk("ab_second_we",  mem_we,   0);
        tick();
        chk("ab_b_ack",      b_ack,    1);
        chk("ab_a_valid_off", a_valid, 0);
        chk("ab_b_rdata",    b_rdata,  8'h3C);
        b_req = 1'b0;
        tick();
        chk("ab_idle_busy",  busy,     0);
        $display("[TB] same-cycle A write / B read, B got %0h", b_rdata);

        // ---- B held against A pulses every cycle; boost, then overrun
        b_req = 1'b1; b_we = 1'b0; b_addr = 7'h40;
        b_ack_cycle = -1;
        av_count = 0;
        for (int n = 0; n < 20; n++) begin
            if (n <= 14) begin
                a_req = 1'b1; a_we = 1'b0; a_addr = 7'(n); a_wdata = 8'h00;
            end else if (n == 15) begin
                a_req = 1'b1; a_we = 1'b1; a_addr = 7'h30; a_wdata = 8'h11;
            end else if (n == 16) begin
                a_req = 1'b1; a_we = 1'b1; a_addr = 7'h30; a_wdata = 8'h22;
            end else begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
            tick();
            chk($sformatf("st_a_valid_%0d", n), a_valid,
                ((n >= 1 && n <= 15) || n == 17) ? 1 : 0);
            chk($sformatf("st_b_ack_%0d", n), b_ack, (n == 16) ? 1 : 0);
            if (a_valid) av_count++;
            if (b_ack && b_ack_cycle < 0) b_ack_cycle = n;
            if (n == 15) begin
                chk("st_boost_addr", mem_addr,  7'h40);
                chk("st_boost_ovr",  a_overrun, 0);
            end
            if (n == 16) begin
                chk("st_pend_we",    mem_we,    1);
                chk("st_pend_addr",  mem_addr,  7'h30);
                chk("st_pend_wdata", mem_wdata, 8'h11);
                chk("st_overrun",    a_overrun, 1);
            end
            $display("[TB] cycle %0d a_valid=%0d b_ack=%0d overrun=%0d",
                     n, a_valid, b_ack, a_overrun);
        end
        chk("st_b_latency",  b_ack_cycle, 16);
        chk("st_av_count",   av_count,    16);
        chk("st_mem30",      mem[7'h30],  8'h11);
        chk("st_ovr_sticky", a_overrun,   1);

        // ---- reset in the middle of an A write to 0x05
        a_req = 1'b1; a_we = 1'b1; a_addr = 7'h05; a_wdata = 8'h77;
        tick();
        a_req = 1'b0;
        chk("mr_mem_we",   mem_we,   1);
        chk("mr_mem_addr", mem_addr, 7'h05);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_we_drop",  mem_we,    0);
        chk("mr_addr0",    mem_addr,  0);
        chk("mr_wdata0",   mem_wdata, 0);
        chk("mr_busy0",    busy,      0);
        chk("mr_ovr0",     a_overrun, 0);
        chk("mr_b_rdata0", b_rdata,   0);
        chk("mr_a_rdata0", a_rdata,   0);
        tick();
        chk("mr_no_valid", a_valid,   0);
        chk("mr_mem05",    mem[7'h05], 8'h00);
        rst_n = 1'b1;
        tick();
        chk("mr_idle",     busy,      0);
        $display("[TB] reset mid-write, mem[05]=%0h", mem[7'h05]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
